// File: rtl/wb_buffer_pkg.sv
// wb_buffer_pkg: shared constants and the line-entry layout for the dcache
// write-back buffer. The localparams are the default geometry; the top-level
// parameters start from them.
package wb_buffer_pkg;

    localparam int WB_DEPTH          = 4;
    localparam int WB_WORDS          = 2;
    localparam int WB_TAG_W          = 28;
    localparam int WB_INDEX_W        = 1;
    localparam int WB_DATA_W         = 32;
    localparam int WB_HOLDOFF_MARGIN = 1;

    // Byte-enable width of one data word.
    localparam int WB_MASK_W = WB_DATA_W / 8;
    // Slot pointer, occupancy counter and word-select widths.
    localparam int WB_PTR_W  = $clog2(WB_DEPTH);
    localparam int WB_SIZE_W = WB_PTR_W + 1;
    localparam int WB_BANK_W = $clog2(WB_WORDS);

    // One buffered line: word 0 sits in the least significant bits of data.
    typedef struct packed {
        logic                                   valid;
        logic [WB_TAG_W-1:0]                    tag;
        logic [WB_INDEX_W-1:0]                  index;
        logic [WB_WORDS-1:0][WB_DATA_W-1:0]     data;
    } wb_entry_t;

endpackage

// File: rtl/wb_match_unit.sv
// wb_match_unit: DEPTH-way {tag,index} comparator. When several valid slots
// match, the one written most recently (nearest to tail) wins.
module wb_match_unit
    import wb_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH,
    parameter int KEY_W = WB_TAG_W + WB_INDEX_W,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] slotValid,
    input  logic [KEY_W-1:0] slotKey [DEPTH],
    input  logic [KEY_W-1:0] queryKey,
    input  logic [PTR_W-1:0] tail,
    output logic             hit,
    output logic [PTR_W-1:0] slotId
);

    logic [PTR_W-1:0] probe;

    // Walk slots from newest (tail-1) to oldest; the first valid match is kept.
    always_comb begin
        hit    = 1'b0;
        slotId = '0;
        probe  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            probe = tail - PTR_W'(k) - 1'b1;
            if (!hit && slotValid[probe] && (slotKey[probe] == queryKey)) begin
                hit    = 1'b1;
                slotId = probe;
            end
        end
    end

endmodule

// File: rtl/write_back_buffer.sv
// write_back_buffer: holds up to DEPTH evicted dirty lines and drains them one
// word per handshake toward the memory-side write master, while forwarding
// CPU query hits out of the buffered lines.
// Optional feature macro: WB_WRITE_MERGE_EN adds byte-masked merging of CPU
// stores into a buffered line (query_data/query_wmask/query_write/query_merged).
//
// Handshake rules: a word moves when deq_data_valid && deq_data_ready at the
// rising clock edge; a line is accepted when enq_valid && enq_ready at the
// rising edge. enq_ready depends only on the registered occupancy, so a full
// buffer never admits a line in the cycle its head line finishes draining.
module write_back_buffer
    import wb_buffer_pkg::*;
#(
    parameter int DEPTH          = WB_DEPTH,
    parameter int WORDS          = WB_WORDS,
    parameter int TAG_W          = WB_TAG_W,
    parameter int INDEX_W        = WB_INDEX_W,
    parameter int DATA_W         = WB_DATA_W,
    parameter int HOLDOFF_MARGIN = WB_HOLDOFF_MARGIN
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    input  logic [TAG_W-1:0]          enq_tag,
    input  logic [INDEX_W-1:0]        enq_index,
    input  logic [WORDS*DATA_W-1:0]   enq_data,
    input  logic [TAG_W-1:0]          query_tag,
    input  logic [INDEX_W-1:0]        query_index,
    input  logic [$clog2(WORDS)-1:0]  query_bank,
`ifdef WB_WRITE_MERGE_EN
    input  logic [DATA_W-1:0]         query_data,
    input  logic [DATA_W/8-1:0]       query_wmask,
    input  logic                      query_write,
    output logic                      query_merged,
`endif
    output logic                      resp_valid,
    output logic [DATA_W-1:0]         resp_bits,
    output logic                      deq_addr_valid,
    output logic [TAG_W-1:0]          deq_addr_tag,
    output logic [INDEX_W-1:0]        deq_addr_index,
    output logic                      deq_data_valid,
    input  logic                      deq_data_ready,
    output logic [DATA_W-1:0]         deq_data_bits,
    output logic                      deq_last,
    output logic                      hold_off_new_miss,
    output logic [$clog2(DEPTH):0]    size
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int BANK_W = $clog2(WORDS);
    localparam int KEY_W  = TAG_W + INDEX_W;
    localparam logic [PTR_W:0]    FULL_COUNT  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]    MARGIN      = (PTR_W + 1)'(HOLDOFF_MARGIN);
    localparam logic [BANK_W-1:0] LAST_WORD   = BANK_W'(WORDS - 1);

    // Same layout as wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic                           valid;
        logic [TAG_W-1:0]               tag;
        logic [INDEX_W-1:0]             index;
        logic [WORDS-1:0][DATA_W-1:0]   data;
    } entry_t;

    entry_t            slots [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [BANK_W-1:0] wordPtr;
    logic [PTR_W:0]    count;

    logic              lineReady;
    logic              enqFire;
    logic              deqFire;
    logic              lastFire;
    logic [DEPTH-1:0]  slotValid;
    logic [KEY_W-1:0]  slotKey [DEPTH];
    logic              hit;
    logic [PTR_W-1:0]  hitSlot;

    assign lineReady         = (count != '0);
    assign enq_ready         = (count != FULL_COUNT);
    assign hold_off_new_miss = ((FULL_COUNT - count) <= MARGIN);
    assign size              = count;

    // The head line drives the memory side; outputs read zero while empty.
    assign deq_addr_valid = lineReady;
    assign deq_data_valid = lineReady;
    assign deq_addr_tag   = lineReady ? slots[head].tag : '0;
    assign deq_addr_index = lineReady ? slots[head].index : '0;
    assign deq_data_bits  = lineReady ? slots[head].data[wordPtr] : '0;
    assign deq_last       = lineReady && (wordPtr == LAST_WORD);

    assign enqFire  = enq_valid && enq_ready;
    assign deqFire  = lineReady && deq_data_ready;
    assign lastFire = deqFire && deq_last;

    // Flatten slot state into the comparator's key/valid vectors.
    always_comb begin
        slotValid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slotValid[i] = slots[i].valid;
            slotKey[i]   = {slots[i].tag, slots[i].index};
        end
    end

    wb_match_unit #(
        .DEPTH (DEPTH),
        .KEY_W (KEY_W),
        .PTR_W (PTR_W)
    ) matchUnit (
        .slotValid (slotValid),
        .slotKey   (slotKey),
        .queryKey  ({query_tag, query_index}),
        .tail      (tail),
        .hit       (hit),
        .slotId    (hitSlot)
    );

    assign resp_valid = hit;
    assign resp_bits  = hit ? slots[hitSlot].data[query_bank] : '0;

`ifdef WB_WRITE_MERGE_EN
    logic mergeFire;
    // A head line that has started (or is starting) to drain must not change.
    assign mergeFire    = query_write && hit &&
                          !((hitSlot == head) && ((wordPtr != '0) || deqFire));
    assign query_merged = mergeFire;
`endif

    // Queue pointers, drain word pointer and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head    <= '0;
            tail    <= '0;
            wordPtr <= '0;
            count   <= '0;
        end else begin
            if (enqFire) begin
                tail <= tail + 1'b1;
            end
            if (lastFire) begin
                wordPtr <= '0;
                head    <= head + 1'b1;
            end else if (deqFire) begin
                wordPtr <= wordPtr + 1'b1;
            end
            if (enqFire && !lastFire) begin
                count <= count + 1'b1;
            end else if (!enqFire && lastFire) begin
                count <= count - 1'b1;
            end
        end
    end

    // Slot storage: fill at tail, retire at head, optional byte merge on a hit.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            if (lastFire) begin
                slots[head].valid <= 1'b0;
            end
            if (enqFire) begin
                slots[tail].valid <= 1'b1;
                slots[tail].tag   <= enq_tag;
                slots[tail].index <= enq_index;
                slots[tail].data  <= enq_data;
            end
`ifdef WB_WRITE_MERGE_EN
            if (mergeFire) begin
                for (int b = 0; b < DATA_W / 8; b++) begin
                    if (query_wmask[b]) begin
                        slots[hitSlot].data[query_bank][b*8 +: 8] <= query_data[b*8 +: 8];
                    end
                end
            end
`endif
        end
    end

endmodule

// File: tb/tb_write_back_buffer.sv
// tb_write_back_buffer: directed self-checking bench for write_back_buffer
// (default geometry: DEPTH=4, WORDS=2, DATA_W=32). Merge cases are compiled
// in when WB_WRITE_MERGE_EN is defined.
module tb_write_back_buffer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enq_valid;
    logic        enq_ready;
    logic [27:0] enq_tag;
    logic [0:0]  enq_index;
    logic [63:0] enq_data;
    logic [27:0] query_tag;
    logic [0:0]  query_index;
    logic [0:0]  query_bank;
`ifdef WB_WRITE_MERGE_EN
    logic [31:0] query_data;
    logic [3:0]  query_wmask;
    logic        query_write;
    logic        query_merged;
`endif
    logic        resp_valid;
    logic [31:0] resp_bits;
    logic        deq_addr_valid;
    logic [27:0] deq_addr_tag;
    logic [0:0]  deq_addr_index;
    logic        deq_data_valid;
    logic        deq_data_ready;
    logic [31:0] deq_data_bits;
    logic        deq_last;
    logic        hold_off_new_miss;
    logic [2:0]  size;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [31:0] expQ [$];
    logic [27:0] tagQ [$];
    int          expWordPtr = 0;

    write_back_buffer dut (
        .clock             (clock),
        .reset             (reset),
        .enq_valid         (enq_valid),
        .enq_ready         (enq_ready),
        .enq_tag           (enq_tag),
        .enq_index         (enq_index),
        .enq_data          (enq_data),
        .query_tag         (query_tag),
        .query_index       (query_index),
        .query_bank        (query_bank),
`ifdef WB_WRITE_MERGE_EN
        .query_data        (query_data),
        .query_wmask       (query_wmask),
        .query_write       (query_write),
        .query_merged      (query_merged),
`endif
        .resp_valid        (resp_valid),
        .resp_bits         (resp_bits),
        .deq_addr_valid    (deq_addr_valid),
        .deq_addr_tag      (deq_addr_tag),
        .deq_addr_index    (deq_addr_index),
        .deq_data_valid    (deq_data_valid),
        .deq_data_ready    (deq_data_ready),
        .deq_data_bits     (deq_data_bits),
        .deq_last          (deq_last),
        .hold_off_new_miss (hold_off_new_miss),
        .size              (size)
    );

    // Clock
    always #5 clock = ~clock;

    task automatic checkValue(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nFails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock: inputs were set at a falling edge, outputs checked at the next.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic enqueue(input logic [27:0] tag, input logic [0:0] idx,
                           input logic [31:0] w0, input logic [31:0] w1);
        enq_valid = 1'b1;
        enq_tag   = tag;
        enq_index = idx;
        enq_data  = {w1, w0};
        tick();
        enq_valid = 1'b0;
        expQ.push_back(w0);
        expQ.push_back(w1);
        tagQ.push_back(tag);
    endtask

    task automatic setQuery(input logic [27:0] tag, input logic [0:0] idx,
                            input logic [0:0] bank);
        query_tag   = tag;
        query_index = idx;
        query_bank  = bank;
    endtask

    // Drain nWords words against the expected queues, optionally stalling
    // every other cycle; bounded by a cycle budget.
    task automatic drainWords(input int nWords, input bit toggle);
        int done = 0;
        int cyc  = 0;
        while (done < nWords && cyc < 100 && expQ.size() > 0) begin
            deq_data_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            checkValue("drain_data", deq_data_bits, expQ[0]);
            checkValue("drain_last", deq_last, expWordPtr == 1);
            checkValue("drain_tag", deq_addr_tag, tagQ[0]);
            tick();
            if (deq_data_ready) begin
                void'(expQ.pop_front());
                done++;
                if (expWordPtr == 1) begin
                    expWordPtr = 0;
                    void'(tagQ.pop_front());
                end else begin
                    expWordPtr = 1;
                end
            end
            cyc++;
        end
        deq_data_ready = 1'b0;
        checkValue("drain_count", done, nWords);
    endtask

    initial begin
        enq_valid      = 1'b0;
        enq_tag        = '0;
        enq_index      = '0;
        enq_data       = '0;
        deq_data_ready = 1'b0;
        setQuery(28'h0, 1'b0, 1'b0);
`ifdef WB_WRITE_MERGE_EN
        query_data  = '0;
        query_wmask = '0;
        query_write = 1'b0;
`endif
        // Reset state
        repeat (2) @(negedge clock);
        checkValue("rst_size", size, 0);
        checkValue("rst_enq_ready", enq_ready, 1);
        checkValue("rst_deq_valid", deq_data_valid, 0);
        checkValue("rst_addr_valid", deq_addr_valid, 0);
        checkValue("rst_last", deq_last, 0);
        checkValue("rst_holdoff", hold_off_new_miss, 0);
        checkValue("rst_resp_valid", resp_valid, 0);
        reset = 1'b1;
        @(negedge clock);

        // Single line: no same-cycle bypass, then two words with last on word 1
        deq_data_ready = 1'b1;
        enq_valid = 1'b1;
        enq_tag   = 28'h1234;
        enq_index = 1'b0;
        enq_data  = {32'hB, 32'hA};
        checkValue("t1_no_bypass", deq_data_valid, 0);
        tick();
        enq_valid = 1'b0;
        expQ.push_back(32'hA);
        expQ.push_back(32'hB);
        tagQ.push_back(28'h1234);
        checkValue("t1_size1", size, 1);
        checkValue("t1_addr_valid", deq_addr_valid, 1);
        drainWords(2, 1'b0);
        checkValue("t1_size0", size, 0);
        checkValue("t1_empty", deq_data_valid, 0);

        // Fill to DEPTH; hold-off from size 3
        for (int i = 0; i < 4; i++) begin
            enqueue(28'h10 + 28'(i), 1'b0, 32'h100 + 32'(i), 32'h200 + 32'(i));
            checkValue("fill_size", size, i + 1);
            checkValue("fill_holdoff", hold_off_new_miss, (i + 1) >= 3);
        end
        checkValue("full_enq_ready", enq_ready, 0);
        deq_data_ready = 1'b1;
        checkValue("full_word0", deq_data_bits, 32'h100);
        tick();
        void'(expQ.pop_front());
        expWordPtr = 1;
        // Last word leaves while an enqueue is offered: enqueue must be refused
        enq_valid = 1'b1;
        enq_tag   = 28'h99;
        enq_data  = {32'h9999, 32'h9998};
        checkValue("full_last", deq_last, 1);
        checkValue("full_last_enq_ready", enq_ready, 0);
        tick();
        enq_valid      = 1'b0;
        deq_data_ready = 1'b0;
        void'(expQ.pop_front());
        void'(tagQ.pop_front());
        expWordPtr = 0;
        checkValue("after_last_size", size, 3);
        checkValue("after_last_enq_ready", enq_ready, 1);
        checkValue("after_last_tag", deq_addr_tag, 28'h11);
        // Stalled drain of the remaining three lines
        drainWords(6, 1'b1);
        checkValue("stall_drain_size", size, 0);

        // Newest-first forwarding among duplicate tags
        enqueue(28'h55, 1'b0, 32'h2A, 32'h2B);
        enqueue(28'h55, 1'b0, 32'h3A, 32'h3B);
        setQuery(28'h55, 1'b0, 1'b1);
        #1;
        checkValue("q_hit", resp_valid, 1);
        checkValue("q_bank1", resp_bits, 32'h3B);
        setQuery(28'h55, 1'b0, 1'b0);
        #1;
        checkValue("q_bank0", resp_bits, 32'h3A);
        setQuery(28'h56, 1'b0, 1'b0);
        #1;
        checkValue("q_miss_tag", resp_valid, 0);
        checkValue("q_miss_bits", resp_bits, 0);
        setQuery(28'h55, 1'b1, 1'b0);
        #1;
        checkValue("q_miss_index", resp_valid, 0);
        drainWords(4, 1'b0);
        setQuery(28'h55, 1'b0, 1'b1);
        #1;
        checkValue("q_after_drain", resp_valid, 0);

`ifdef WB_WRITE_MERGE_EN
        // Merge into a non-head line is accepted
        enqueue(28'h70, 1'b0, 32'h33334444, 32'h11112222);
        enqueue(28'h71, 1'b0, 32'h77778888, 32'h55556666);
        setQuery(28'h71, 1'b0, 1'b0);
        query_data  = 32'hFFFFFFFF;
        query_wmask = 4'b0011;
        query_write = 1'b1;
        #1;
        checkValue("m_accept", query_merged, 1);
        tick();
        query_write = 1'b0;
        expQ[2] = 32'h7777FFFF;
        checkValue("m_data", resp_bits, 32'h7777FFFF);
        // Head with word_ptr=1 refuses the merge
        deq_data_ready = 1'b1;
        tick();
        deq_data_ready = 1'b0;
        void'(expQ.pop_front());
        expWordPtr = 1;
        setQuery(28'h70, 1'b0, 1'b1);
        query_write = 1'b1;
        #1;
        checkValue("m_refuse", query_merged, 0);
        tick();
        query_write = 1'b0;
        checkValue("m_untouched", resp_bits, 32'h11112222);
`endif

        // Reset in the middle of a burst
        enqueue(28'h80, 1'b0, 32'h1, 32'h2);
        deq_data_ready = 1'b1;
        checkValue("mid_valid", deq_data_valid, 1);
        tick();
        setQuery(28'h80, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        checkValue("mid_rst_size", size, 0);
        checkValue("mid_rst_valid", deq_data_valid, 0);
        checkValue("mid_rst_last", deq_last, 0);
        checkValue("mid_rst_enq_ready", enq_ready, 1);
        checkValue("mid_rst_resp", resp_valid, 0);
        deq_data_ready = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
